dmem_arbiter: RTL

Two-port arbiter that shares the single-ported data memory between the CPU load/store path (port 0) and the debug/program-loader path (port 1). It sits between both requesters and `data_mem`, serialises their accesses through a small FSM, supports short locked bursts, and returns read data to the owner of each access. All memory-side strobes are registered, so the memory sees glitch-free, one-cycle access pulses.

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU
// load/store path (port 0) and the debug/program-loader path (port 1).
// Accesses are serialised through a three-state FSM. An owner may keep the
// memory for up to MAX_BURST back-to-back accesses by holding lock.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   pN_req/we/addr/wdata  access command from port N, held until pN_gnt
//   pN_lock               ask to keep ownership for the following access
//   pN_gnt                one-cycle pulse, access issued to memory
//   pN_rvalid, pN_rdata   read response for port N
//   mem_read/mem_write    registered one-cycle memory strobes
//   mem_addr/mem_wdata    registered command, held between accesses
//   mem_rdata             memory read data, valid the cycle after mem_read
//   busy, owner           FSM not idle / port currently or last granted
//
// state | meaning
// IDLE  | arbitrate, register the winner's command
// ISSUE | memory strobe and gnt high for this cycle
// RESP  | rvalid high for this cycle (reads only)
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int BEAT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              resp_owner_q;
  logic              load;
  logic              sel;
  logic              winner;
  logic              own_req, own_lock, cont;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign own_req  = owner_q ? p1_req  : p0_req;
  assign own_lock = owner_q ? p1_lock : p0_lock;
  assign cont     = own_req && own_lock && (beats_q < BEAT_W'(MAX_BURST));

  // Single requester always wins; a tie goes to port 0 or to the port that
  // did not win last time.
  always_comb begin
    winner = p1_req;
    if (p0_req && p1_req) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    load         = 1'b0;
    sel          = owner_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d      = ISSUE;
          load         = 1'b1;
          sel          = winner;
          owner_d      = winner;
          last_owner_d = winner;
          beats_d      = BEAT_W'(1);
        end
      end
      ISSUE, RESP: begin
        if (state_q == ISSUE && mem_read) begin
          state_d = RESP;
        end else if (cont) begin
          // locked continuation: no arbitration, same owner
          state_d = ISSUE;
          load    = 1'b1;
          beats_d = beats_q + BEAT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_q      <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      resp_owner_q <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_gnt       <= 1'b0;
      p1_gnt       <= 1'b0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      mem_read     <= load && !sel_we;
      mem_write    <= load && sel_we;
      p0_gnt       <= load && !sel;
      p1_gnt       <= load && sel;
      if (load) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      p0_rvalid <= (state_q == ISSUE) && mem_read && !owner_q;
      p1_rvalid <= (state_q == ISSUE) && mem_read && owner_q;
      if ((state_q == ISSUE) && mem_read) begin
        resp_owner_q <= owner_q;
      end
    end
  end

  assign p0_rdata = (p0_rvalid && !resp_owner_q) ? mem_rdata : '0;
  assign p1_rdata = (p1_rvalid && resp_owner_q)  ? mem_rdata : '0;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;

endmodule
